// File: rtl/mem_latency_monitor.sv
`default_nettype none
// =============================================================================
// mem_latency_monitor : passive req/gnt/rvalid observer measuring in-order
//                       request-to-response latency (last/min/max/count).
// Revision: 1.0 - initial release
// =============================================================================
module mem_latency_monitor #(
   parameter int LAT_WIDTH       = 16,
   parameter int CNT_WIDTH       = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clear_i,
   input  logic                               req_i,
   input  logic                               gnt_i,
   input  logic                               rvalid_i,
   output logic                               sample_valid_o,
   output logic [LAT_WIDTH-1:0]               last_latency_o,
   output logic [LAT_WIDTH-1:0]               min_latency_o,
   output logic [LAT_WIDTH-1:0]               max_latency_o,
   output logic [CNT_WIDTH-1:0]               sample_count_o,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               overflow_err_o,
   output logic                               underflow_err_o
);
   localparam int                 PTR_W    = $clog2(MAX_OUTSTANDING);
   localparam int                 OCC_W    = PTR_W + 1;
   localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [OCC_W-1:0]   OCC_FULL = OCC_W'(MAX_OUTSTANDING);
   localparam logic [OCC_W-1:0]   OCC_ONE  = OCC_W'(1);
   localparam logic [0:0]         ST_IDLE     = 1'b0;
   localparam logic [0:0]         ST_TRACKING = 1'b1;

   logic [0:0]                 state;
   logic [0:0]                 state_nxt;
   logic                       tracking;
   logic [LAT_WIDTH-1:0]       age [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] valid;
   logic [MAX_OUTSTANDING-1:0] valid_nxt;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [OCC_W-1:0]           occ;
   logic                       accept;
   logic                       full;
   logic                       pop;
   logic                       push;
   logic [LAT_WIDTH-1:0]       head_age;

   assign accept   = req_i & gnt_i;
   assign full     = (occ == OCC_FULL);
   // A response only completes an entry that existed before this cycle.
   assign pop      = rvalid_i & tracking;
   assign push     = accept & (~full | pop);
   assign head_age = age[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (accept) state_nxt = ST_TRACKING;
         ST_TRACKING: if (pop && !push && occ == OCC_ONE) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tracking = (state == ST_TRACKING);
   end

   always_comb begin
      valid_nxt = valid;
      if (pop)  valid_nxt[rd_ptr] = 1'b0;
      if (push) valid_nxt[wr_ptr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         valid  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
         valid <= valid_nxt;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (!rst_n)
            age[i] <= '0;
         else if (push && wr_ptr == PTR_W'(i))
            age[i] <= LAT_WIDTH'(1);
         else if (valid[i] && age[i] != LAT_MAX)
            age[i] <= age[i] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         sample_valid_o  <= 1'b0;
         last_latency_o  <= '0;
         min_latency_o   <= LAT_MAX;
         max_latency_o   <= '0;
         sample_count_o  <= '0;
         overflow_err_o  <= 1'b0;
         underflow_err_o <= 1'b0;
      end else begin
         sample_valid_o <= pop;
         if (pop) begin
            last_latency_o <= head_age;
            if (head_age < min_latency_o) min_latency_o <= head_age;
            if (head_age > max_latency_o) max_latency_o <= head_age;
            if (sample_count_o != CNT_MAX) sample_count_o <= sample_count_o + 1'b1;
         end
         if (accept && full && !pop) overflow_err_o  <= 1'b1;
         if (rvalid_i && !tracking)  underflow_err_o <= 1'b1;
      end
   end

   assign outstanding_o = occ;

endmodule
`default_nettype wire

// File: tb/tb_mem_latency_monitor.sv
`default_nettype none
// =============================================================================
// tb_mem_latency_monitor : table-driven and directed checks of the monitor.
// Revision: 1.0 - initial release
// =============================================================================
module tb_mem_latency_monitor;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic req = 1'b0;
   logic gnt = 1'b0;
   logic rvalid = 1'b0;

   logic        sv;
   logic [15:0] last, minl, maxl;
   logic [31:0] cnt;
   logic [2:0]  outs;
   logic        ovf, unf;

   logic        s_sv;
   logic [3:0]  s_last, s_minl, s_maxl;
   logic [1:0]  s_cnt;
   logic [2:0]  s_outs;
   logic        s_ovf, s_unf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_latency_monitor dut (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .req_i(req), .gnt_i(gnt),
      .rvalid_i(rvalid), .sample_valid_o(sv), .last_latency_o(last),
      .min_latency_o(minl), .max_latency_o(maxl), .sample_count_o(cnt),
      .outstanding_o(outs), .overflow_err_o(ovf), .underflow_err_o(unf)
   );

   mem_latency_monitor #(.LAT_WIDTH(4), .CNT_WIDTH(2), .MAX_OUTSTANDING(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .clear_i(clear), .req_i(req), .gnt_i(gnt),
      .rvalid_i(rvalid), .sample_valid_o(s_sv), .last_latency_o(s_last),
      .min_latency_o(s_minl), .max_latency_o(s_maxl), .sample_count_o(s_cnt),
      .outstanding_o(s_outs), .overflow_err_o(s_ovf), .underflow_err_o(s_unf)
   );

   typedef struct {
      logic        req;
      logic        rv;
      logic        clr;
      logic        v;
      logic [15:0] last;
      logic [15:0] min;
      logic [15:0] max;
      logic [31:0] cnt;
      logic [2:0]  out;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs; outputs are sampled 1ns after the edge.
   task automatic cyc(input logic r, input logic v, input logic c);
      req = r; gnt = r; rvalid = v; clear = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   int pulses;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd1};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd1};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd3,    16'd3, 32'd1, 3'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 16'd3,    16'd3, 32'd1, 3'd0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd2};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd3};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 32'd0, 3'd3};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 16'd4,    16'd4, 32'd1, 3'd2};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 16'd4,    16'd4, 32'd1, 3'd2};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'd4,    16'd5, 32'd2, 3'd1};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 16'd4,    16'd5, 32'd3, 3'd0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 16'd4,    16'd5, 32'd3, 3'd0};

      do_reset();
      chk("reset_valid", sv, 0);
      chk("reset_last", last, 0);
      chk("reset_min", minl, 16'hFFFF);
      chk("reset_max", maxl, 0);
      chk("reset_count", cnt, 0);
      chk("reset_outstanding", outs, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_unf", unf, 0);

      // Single access, clear, then pipelined accesses.
      for (int i = 0; i < 15; i++) begin
         cyc(tbl[i].req, tbl[i].rv, tbl[i].clr);
         chk($sformatf("tbl%0d_valid", i), sv, tbl[i].v);
         chk($sformatf("tbl%0d_last", i), last, tbl[i].last);
         chk($sformatf("tbl%0d_min", i), minl, tbl[i].min);
         chk($sformatf("tbl%0d_max", i), maxl, tbl[i].max);
         chk($sformatf("tbl%0d_count", i), cnt, tbl[i].cnt);
         chk($sformatf("tbl%0d_outstanding", i), outs, tbl[i].out);
         chk($sformatf("tbl%0d_errs", i), {ovf, unf}, 0);
      end

      // Back-to-back accept and response every cycle.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         chk($sformatf("b2b%0d_valid", i), sv, 1);
         chk($sformatf("b2b%0d_last", i), last, 1);
         chk($sformatf("b2b%0d_outstanding", i), outs, 1);
      end
      chk("b2b_count", cnt, 20);
      chk("b2b_min", minl, 1);
      chk("b2b_max", maxl, 1);
      chk("b2b_ovf", ovf, 0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("b2b_drain_outstanding", outs, 0);

      // Overflow then underflow.
      do_reset();
      repeat (5) cyc(1'b1, 1'b0, 1'b0);
      chk("ovf_outstanding", outs, 4);
      chk("ovf_flag", ovf, 1);
      chk("ovf_unf_clear", unf, 0);
      pulses = 0;
      repeat (5) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (sv) pulses++;
      end
      chk("unf_pulses", pulses, 4);
      chk("unf_count", cnt, 4);
      chk("unf_last", last, 5);
      chk("unf_flag", unf, 1);
      chk("unf_outstanding", outs, 0);

      // Latency and count saturation in the narrow instance.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      repeat (39) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("sat_wide_last", last, 40);
      chk("sat_narrow_last", s_last, 15);
      chk("sat_narrow_max", s_maxl, 15);
      repeat (4) begin
         cyc(1'b1, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b0);
      end
      chk("sat_narrow_count", s_cnt, 3);
      chk("sat_wide_count", cnt, 5);
      chk("sat_narrow_min", s_minl, 1);

      // Clear coincident with a completing response.
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      chk("clr_valid", sv, 0);
      chk("clr_last", last, 0);
      chk("clr_min", minl, 16'hFFFF);
      chk("clr_max", maxl, 0);
      chk("clr_count", cnt, 0);
      chk("clr_outstanding", outs, 1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("clr_next_valid", sv, 1);
      chk("clr_next_last", last, 2);
      chk("clr_next_count", cnt, 1);
      chk("clr_next_unf", unf, 0);

      // Reset with entries outstanding.
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      chk("rst_pre_outstanding", outs, 3);
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      chk("rst_outstanding", outs, 0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("rst_unf", unf, 1);
      chk("rst_no_sample", sv, 0);

      // Accept and response together into an empty tracker.
      do_reset();
      cyc(1'b1, 1'b1, 1'b0);
      chk("empty_both_unf", unf, 1);
      chk("empty_both_valid", sv, 0);
      chk("empty_both_outstanding", outs, 1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("empty_both_next_valid", sv, 1);
      chk("empty_both_next_last", last, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
